sad_window_accumulator: RTL
===========================

# sad_window_accumulator

Parametrised, pipelined sum-of-absolute-differences engine for the stereo matching datapath. Each beat accepts NUM_CH pixel pairs (left/right candidate), forms per-lane absolute differences, sums the lanes, and accumulates over WINDOW beats. It emits one SAD cost per window with a one-cycle valid strobe, for the disparity-selection stage downstream. It generalises the single-pair registered absolute-difference unit with lane count, windowed accumulation, valid tracking, abort, and saturation.

## Interface
- NUM_BITS, 8, pixel width per lane
- NUM_CH, 4, lanes per beat (≥1)
- WINDOW, 8, beats accumulated per SAD result (≥1)
- OUT_BITS, 13, width of accumulator and result; if narrower than NUM_BITS+clog2(NUM_CH*WINDOW), saturation applies
- clock  in  1  single clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous abort of the current window
- in_valid  in  1  beat qualifier
- in1  in  NUM_CH*NUM_BITS  left pixels; lane k = in1[k*NUM_BITS +: NUM_BITS]
- in2  in  NUM_CH*NUM_BITS  right pixels, same packing
- out_valid  out  1  one-cycle strobe: out_sad/out_sat are new
- out_sad  out  OUT_BITS  windowed SAD, held between strobes
- out_sat  out  1  result was clamped, held with out_sad
- beat_count  out  clog2(WINDOW+1)  beats accepted in the current window

## Operation
- Stage 1 (registered): per lane d_k = (a>b) ? a-b : b-a, unsigned NUM_BITS. Equal inputs give 0. v1 <= in_valid.
- Stage 2 (registered): s = Σ d_k, width NUM_BITS+clog2(NUM_CH), no overflow possible. v2 <= v1.
- Stage 3: on v2, acc_next = acc + s. If acc_next > 2^OUT_BITS-1, clamp to all-ones and set sticky sat.
  - Final beat of the window (window beat counter == WINDOW-1): out_sad <= clamped acc_next, out_sat <= sat|overflow, out_valid <= 1. acc, sat, and the counter return to 0 in the same cycle.
  - Otherwise: acc <= clamped acc_next, counter += 1.
- beat_count counts input beats accepted (in_valid at the input). It wraps to 0 on the beat that completes the window.
- in_valid low is a bubble: no state advances except pipeline valid bits. Bubbles never terminate a window.
- clear: v1, v2, acc, sat, the window counter, and beat_count go to 0. In-flight beats are discarded. out_sad/out_sat hold their last values. out_valid is 0 in the cycle after clear. A beat presented with clear high is discarded.
- reset: clear behaviour, plus out_sad=0, out_sat=0, out_valid=0.
- No backpressure: the block accepts one beat every cycle.

## Timing
- Reset values: out_valid=0, out_sad=0, out_sat=0, beat_count=0.
- Latency: the last beat of a window is sampled at edge N. out_valid is high for the cycle following edge N+3, with out_sad valid in that cycle.
- Back-to-back windows (continuous in_valid) give an out_valid pulse every WINDOW cycles. With WINDOW=1, out_valid is high every cycle.
- out_valid is never high two consecutive cycles unless WINDOW=1.
- Simultaneous clear and a completing stage-3 beat: clear wins, and no strobe is produced.
- Reset or clear mid-window: the next result covers exactly WINDOW beats accepted after the deassertion.

## Test plan
- Defaults; all lanes in1=200, in2=50 for 8 consecutive beats -> out_sad=4800, out_sat=0, out_valid pulses once, 3 cycles after the 8th beat.
- Symmetry: lanes in1=10, in2=250 and then in1=250, in2=10 (4 beats each); also in1=in2=77 -> per-beat sums 960/960/0, totals correct. Equal inputs contribute 0.
- Random in_valid bubbles (~50%) across 3 windows of random pixels -> out_sad equals the reference-model sum per 8 accepted beats. beat_count tracks accepted beats.
- clear asserted after beat 5 (with beats in flight) -> no strobe. The next 8 beats of in1=1, in2=0 give out_sad=32. out_sad holds its prior value until then.
- OUT_BITS=10, all lanes in1=255, in2=0 for 8 beats -> out_sad=1023, out_sat=1. The next window (all zero) gives out_sad=0, out_sat=0.
- reset mid-window and WINDOW=1 configuration -> outputs 0 after reset. Per-cycle strobes, each equal to that beat's lane sum.

Source files
------------

// File: rtl/sad_window_accumulator.sv
// -----------------------------------------------------------------------------
// sad_window_accumulator
//
// Pipelined sum-of-absolute-differences engine for stereo matching. Each
// accepted beat carries NUM_CH left/right pixel pairs. The block forms the
// per-lane absolute differences, sums the lanes and accumulates the sums over
// WINDOW beats. It then emits one SAD cost per window with a one-cycle strobe.
// If OUT_BITS is too narrow for the worst-case total, the result is clamped to
// all-ones and out_sat is raised.
//
// Pipeline (beat sampled at edge N):
//   edge N   : stage 1 registers the per-lane |a-b|
//   edge N+1 : stage 2 registers the lane sum
//   edge N+2 : stage 3 accumulates; the final beat of a window produces a result
//   edge N+3 : the output register presents out_sad/out_sat with out_valid=1
//
// Ports:
//   clock       single clock, rising edge
//   reset       synchronous, active-high; clears everything including outputs
//   clear       synchronous abort of the current window (outputs hold)
//   in_valid    beat qualifier; low cycles are bubbles
//   in1, in2    left / right pixels, lane k = in[k*NUM_BITS +: NUM_BITS]
//   out_valid   one-cycle strobe marking a new out_sad/out_sat
//   out_sad     windowed SAD, held between strobes
//   out_sat     the held result was clamped
//   beat_count  beats accepted at the input in the current window
//
// Handshake: there is no backpressure. A beat is accepted on every rising edge
// where in_valid=1 and clear=0, and out_valid is a pure strobe with no ready.
// -----------------------------------------------------------------------------
module sad_window_accumulator #(
   parameter int NUM_BITS = 8,
   parameter int NUM_CH   = 4,
   parameter int WINDOW   = 8,
   parameter int OUT_BITS = 13
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        clear,
   input  logic                        in_valid,
   input  logic [NUM_CH*NUM_BITS-1:0]  in1,
   input  logic [NUM_CH*NUM_BITS-1:0]  in2,
   output logic                        out_valid,
   output logic [OUT_BITS-1:0]         out_sad,
   output logic                        out_sat,
   output logic [$clog2(WINDOW+1)-1:0] beat_count
);

   localparam int CNT_W = $clog2(WINDOW + 1);
   // A lane sum can never overflow this width.
   localparam int SUM_W = NUM_BITS + $clog2(NUM_CH);
   // One spare bit above the wider operand so acc + sum is exact before the clamp.
   localparam int ACC_W = ((OUT_BITS > SUM_W) ? OUT_BITS : SUM_W) + 1;

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WINDOW - 1);
   localparam logic [ACC_W-1:0] ACC_MAX   = {{(ACC_W-OUT_BITS){1'b0}}, {OUT_BITS{1'b1}}};

   // ---------------------------------------------------------------------------
   // Stage 1: per-lane absolute difference
   // ---------------------------------------------------------------------------
   logic [NUM_BITS-1:0] diff_d [NUM_CH];
   logic [NUM_BITS-1:0] diff_q [NUM_CH];
   logic                v1_d, v1_q;

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         if (in1[k*NUM_BITS +: NUM_BITS] > in2[k*NUM_BITS +: NUM_BITS]) begin
            diff_d[k] = in1[k*NUM_BITS +: NUM_BITS] - in2[k*NUM_BITS +: NUM_BITS];
         end else begin
            diff_d[k] = in2[k*NUM_BITS +: NUM_BITS] - in1[k*NUM_BITS +: NUM_BITS];
         end
      end
      // A beat presented together with clear is discarded.
      v1_d = in_valid & ~clear;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         diff_q <= '{default: '0};
         v1_q   <= 1'b0;
      end else begin
         diff_q <= diff_d;
         v1_q   <= v1_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 2: lane sum
   // ---------------------------------------------------------------------------
   logic [SUM_W-1:0] sum_d, sum_q;
   logic             v2_d, v2_q;

   always_comb begin
      sum_d = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         sum_d = sum_d + SUM_W'(diff_q[k]);
      end
      v2_d = v1_q & ~clear;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sum_q <= '0;
         v2_q  <= 1'b0;
      end else begin
         sum_q <= sum_d;
         v2_q  <= v2_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 3: windowed accumulation with saturation
   // ---------------------------------------------------------------------------
   logic [OUT_BITS-1:0] acc_d, acc_q;
   logic                sat_d, sat_q;
   logic [CNT_W-1:0]    win_cnt_d, win_cnt_q;
   logic                fin_valid_d, fin_valid_q;
   logic [OUT_BITS-1:0] fin_sad_d, fin_sad_q;
   logic                fin_sat_d, fin_sat_q;
   logic [ACC_W-1:0]    acc_sum;
   logic                acc_ovf;
   logic [OUT_BITS-1:0] acc_clamped;

   always_comb begin
      acc_d       = acc_q;
      sat_d       = sat_q;
      win_cnt_d   = win_cnt_q;
      fin_valid_d = 1'b0;
      fin_sad_d   = fin_sad_q;
      fin_sat_d   = fin_sat_q;

      acc_sum     = ACC_W'(acc_q) + ACC_W'(sum_q);
      acc_ovf     = (acc_sum > ACC_MAX);
      acc_clamped = acc_ovf ? {OUT_BITS{1'b1}} : acc_sum[OUT_BITS-1:0];

      if (clear) begin
         // Clear wins over a completing beat: the window is dropped silently.
         acc_d     = '0;
         sat_d     = 1'b0;
         win_cnt_d = '0;
      end else if (v2_q) begin
         if (win_cnt_q == LAST_BEAT) begin
            fin_valid_d = 1'b1;
            fin_sad_d   = acc_clamped;
            fin_sat_d   = sat_q | acc_ovf;
            acc_d       = '0;
            sat_d       = 1'b0;
            win_cnt_d   = '0;
         end else begin
            acc_d     = acc_clamped;
            sat_d     = sat_q | acc_ovf;
            win_cnt_d = win_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q       <= '0;
         sat_q       <= 1'b0;
         win_cnt_q   <= '0;
         fin_valid_q <= 1'b0;
         fin_sad_q   <= '0;
         fin_sat_q   <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         sat_q       <= sat_d;
         win_cnt_q   <= win_cnt_d;
         fin_valid_q <= fin_valid_d;
         fin_sad_q   <= fin_sad_d;
         fin_sat_q   <= fin_sat_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Output register: strobe plus held result
   // ---------------------------------------------------------------------------
   logic                out_valid_d, out_valid_q;
   logic [OUT_BITS-1:0] out_sad_d, out_sad_q;
   logic                out_sat_d, out_sat_q;

   always_comb begin
      out_valid_d = fin_valid_q & ~clear;
      out_sad_d   = out_sad_q;
      out_sat_d   = out_sat_q;
      // A result still waiting here when clear arrives is in flight, so it is
      // discarded and the previously presented result stays on the outputs.
      if (fin_valid_q && !clear) begin
         out_sad_d = fin_sad_q;
         out_sat_d = fin_sat_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_sad_q   <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_sad_q   <= out_sad_d;
         out_sat_q   <= out_sat_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Input-side beat counter. It runs ahead of the stage-3 window counter by the
   // pipeline depth, and wraps on the beat that completes a window.
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] beat_d, beat_q;

   always_comb begin
      beat_d = beat_q;
      if (clear) begin
         beat_d = '0;
      end else if (in_valid) begin
         beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         beat_q <= '0;
      end else begin
         beat_q <= beat_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_sad    = out_sad_q;
   assign out_sat    = out_sat_q;
   assign beat_count = beat_q;

endmodule
